// File: rtl/udp_rx_chan_packer.sv
// UDP receive front end: per-channel header filter, byte-to-word payload
// packer with tkeep and per-beat metadata, length/error check and packet
// statistics. Single clock; one completed word may be held while the
// output register is stalled.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a header; held word (if any) drains first
// PASS  | datagram matched a channel; bytes are packed into words
// DROP  | datagram matched no channel; bytes are consumed and discarded
module udp_rx_chan_packer #(
    parameter int  DATA_W = 64,
    parameter int  NUM_CH = 4,
    parameter int  CNT_W  = 32,
    localparam int BYTES  = DATA_W / 8,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 s_hdr_valid,
    output logic                 s_hdr_ready,
    input  logic [31:0]          s_hdr_src_ip,
    input  logic [15:0]          s_hdr_src_port,
    input  logic [15:0]          s_hdr_dest_port,
    input  logic [15:0]          s_hdr_udp_length,
    input  logic [7:0]           s_pl_tdata,
    input  logic                 s_pl_tvalid,
    output logic                 s_pl_tready,
    input  logic                 s_pl_tlast,
    input  logic                 s_pl_tuser,
    input  logic [NUM_CH-1:0]    cfg_ch_en,
    input  logic [16*NUM_CH-1:0] cfg_local_port,
    input  logic [32*NUM_CH-1:0] cfg_remote_ip,
    input  logic [16*NUM_CH-1:0] cfg_remote_port,
    output logic [DATA_W-1:0]    m_tdata,
    output logic [BYTES-1:0]     m_tkeep,
    output logic                 m_tvalid,
    input  logic                 m_tready,
    output logic                 m_tlast,
    output logic                 m_terr,
    output logic [CH_W-1:0]      m_tch,
    output logic [31:0]          m_src_ip,
    output logic [15:0]          m_src_port,
    input  logic                 stat_clr,
    output logic [CNT_W-1:0]     stat_rx_pkts,
    output logic [CNT_W-1:0]     stat_drop_pkts,
    output logic [CNT_W-1:0]     stat_err_pkts
);

    localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PASS = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

    logic [1:0]        state;
    logic              rdy_q;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] acc;
    logic              acc_full;
    logic [BYTES-1:0]  hold_keep;
    logic              hold_last;
    logic              hold_err;
    logic [15:0]       byte_cnt;
    logic [15:0]       expected;
    logic [CH_W-1:0]   ch_q;
    logic [31:0]       ip_q;
    logic [15:0]       port_q;

    logic              hdr_fire;
    logic              pl_fire;
    logic              pass_fire;
    logic              match_any;
    logic [CH_W-1:0]   match_idx;
    logic [DATA_W-1:0] merged;
    logic [BYTES-1:0]  cur_keep;
    logic              word_done;
    logic              out_free;
    logic              load_held;
    logic              load_new;
    logic [15:0]       cnt_next;
    logic              last_err;
    logic              err_inc;

    // Header ready is gated one cycle after reset release so it reads 0 in reset.
    assign s_hdr_ready = rdy_q && (state == ST_IDLE) && !acc_full;
    assign s_pl_tready = ((state == ST_PASS) && !acc_full) || (state == ST_DROP);

    assign hdr_fire  = s_hdr_valid && s_hdr_ready;
    assign pl_fire   = s_pl_tvalid && s_pl_tready;
    assign pass_fire = pl_fire && (state == ST_PASS);
    assign word_done = pass_fire && ((idx == IDX_W'(BYTES - 1)) || s_pl_tlast);
    assign out_free  = !m_tvalid || m_tready;
    assign load_held = acc_full && out_free;
    assign load_new  = word_done && out_free && !acc_full;
    assign cnt_next  = (byte_cnt == 16'hFFFF) ? byte_cnt : byte_cnt + 16'd1;
    assign last_err  = s_pl_tuser || (cnt_next != expected);
    assign err_inc   = (load_held && hold_last && hold_err) ||
                       (load_new && s_pl_tlast && last_err);

    // Parallel channel compare; scanning downwards lets the lowest index win.
    always_comb begin
        match_any = 1'b0;
        match_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (cfg_ch_en[i] &&
                (s_hdr_dest_port == cfg_local_port[16*i +: 16]) &&
                ((cfg_remote_ip[32*i +: 32] == 32'd0) ||
                 (cfg_remote_ip[32*i +: 32] == s_hdr_src_ip)) &&
                ((cfg_remote_port[16*i +: 16] == 16'd0) ||
                 (cfg_remote_port[16*i +: 16] == s_hdr_src_port))) begin
                match_any = 1'b1;
                match_idx = CH_W'(i);
            end
        end
    end

    // Accumulator with the incoming byte dropped into its lane, and lanes 0..idx.
    always_comb begin
        merged = acc;
        merged[8*int'(idx) +: 8] = s_pl_tdata;
        cur_keep = '0;
        for (int i = 0; i < BYTES; i++) begin
            cur_keep[i] = (i <= int'(idx));
        end
    end

    // Sequencer and per-datagram context (channel, source, expected length).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            rdy_q    <= 1'b0;
            ch_q     <= '0;
            ip_q     <= 32'd0;
            port_q   <= 16'd0;
            expected <= 16'd0;
            byte_cnt <= 16'd0;
        end else begin
            rdy_q <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (hdr_fire) begin
                        if (match_any) begin
                            state    <= ST_PASS;
                            ch_q     <= match_idx;
                            ip_q     <= s_hdr_src_ip;
                            port_q   <= s_hdr_src_port;
                            expected <= (s_hdr_udp_length < 16'd8) ? 16'd0
                                        : s_hdr_udp_length - 16'd8;
                            byte_cnt <= 16'd0;
                        end else begin
                            state <= ST_DROP;
                        end
                    end
                end
                ST_PASS: begin
                    if (pl_fire) begin
                        byte_cnt <= cnt_next;
                        if (s_pl_tlast) begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_DROP: begin
                    if (pl_fire && s_pl_tlast) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Packing, single-word hold buffer and the output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx        <= '0;
            acc        <= '0;
            acc_full   <= 1'b0;
            hold_keep  <= '0;
            hold_last  <= 1'b0;
            hold_err   <= 1'b0;
            m_tdata    <= '0;
            m_tkeep    <= '0;
            m_tvalid   <= 1'b0;
            m_tlast    <= 1'b0;
            m_terr     <= 1'b0;
            m_tch      <= '0;
            m_src_ip   <= 32'd0;
            m_src_port <= 16'd0;
        end else begin
            if (pass_fire) begin
                idx <= word_done ? '0 : idx + IDX_W'(1);
            end
            if (load_held) begin
                m_tvalid   <= 1'b1;
                m_tdata    <= acc;
                m_tkeep    <= hold_keep;
                m_tlast    <= hold_last;
                m_terr     <= hold_err;
                m_tch      <= ch_q;
                m_src_ip   <= ip_q;
                m_src_port <= port_q;
                acc        <= '0;
                acc_full   <= 1'b0;
            end else if (load_new) begin
                m_tvalid   <= 1'b1;
                m_tdata    <= merged;
                m_tkeep    <= cur_keep;
                m_tlast    <= s_pl_tlast;
                m_terr     <= s_pl_tlast && last_err;
                m_tch      <= ch_q;
                m_src_ip   <= ip_q;
                m_src_port <= port_q;
                acc        <= '0;
            end else if (word_done) begin
                acc       <= merged;
                hold_keep <= cur_keep;
                hold_last <= s_pl_tlast;
                hold_err  <= s_pl_tlast && last_err;
                acc_full  <= 1'b1;
            end else begin
                if (pass_fire) begin
                    acc <= merged;
                end
                if (m_tvalid && m_tready) begin
                    m_tvalid <= 1'b0;
                end
            end
        end
    end

    // Statistics; a clear wins over any increment in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_rx_pkts   <= '0;
            stat_drop_pkts <= '0;
            stat_err_pkts  <= '0;
        end else if (stat_clr) begin
            stat_rx_pkts   <= '0;
            stat_drop_pkts <= '0;
            stat_err_pkts  <= '0;
        end else begin
            if (hdr_fire && match_any) begin
                stat_rx_pkts <= stat_rx_pkts + CNT_W'(1);
            end
            if (hdr_fire && !match_any) begin
                stat_drop_pkts <= stat_drop_pkts + CNT_W'(1);
            end
            if (err_inc) begin
                stat_err_pkts <= stat_err_pkts + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_udp_rx_chan_packer.sv
// Bench for udp_rx_chan_packer: directed scenarios plus randomized traffic,
// all outputs scored against a queue of expected beats built from the
// datagram contents and the channel table.
module tb_udp_rx_chan_packer;

    localparam int DATA_W = 64;
    localparam int NUM_CH = 4;
    localparam int CNT_W  = 32;
    localparam int BYTES  = DATA_W / 8;
    localparam int CH_W   = 2;

    logic                 clk;
    logic                 rst_n;
    logic                 s_hdr_valid;
    logic                 s_hdr_ready;
    logic [31:0]          s_hdr_src_ip;
    logic [15:0]          s_hdr_src_port;
    logic [15:0]          s_hdr_dest_port;
    logic [15:0]          s_hdr_udp_length;
    logic [7:0]           s_pl_tdata;
    logic                 s_pl_tvalid;
    logic                 s_pl_tready;
    logic                 s_pl_tlast;
    logic                 s_pl_tuser;
    logic [NUM_CH-1:0]    cfg_ch_en;
    logic [16*NUM_CH-1:0] cfg_local_port;
    logic [32*NUM_CH-1:0] cfg_remote_ip;
    logic [16*NUM_CH-1:0] cfg_remote_port;
    logic [DATA_W-1:0]    m_tdata;
    logic [BYTES-1:0]     m_tkeep;
    logic                 m_tvalid;
    logic                 m_tready;
    logic                 m_tlast;
    logic                 m_terr;
    logic [CH_W-1:0]      m_tch;
    logic [31:0]          m_src_ip;
    logic [15:0]          m_src_port;
    logic                 stat_clr;
    logic [CNT_W-1:0]     stat_rx_pkts;
    logic [CNT_W-1:0]     stat_drop_pkts;
    logic [CNT_W-1:0]     stat_err_pkts;

    udp_rx_chan_packer #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_hdr_valid(s_hdr_valid), .s_hdr_ready(s_hdr_ready),
        .s_hdr_src_ip(s_hdr_src_ip), .s_hdr_src_port(s_hdr_src_port),
        .s_hdr_dest_port(s_hdr_dest_port), .s_hdr_udp_length(s_hdr_udp_length),
        .s_pl_tdata(s_pl_tdata), .s_pl_tvalid(s_pl_tvalid), .s_pl_tready(s_pl_tready),
        .s_pl_tlast(s_pl_tlast), .s_pl_tuser(s_pl_tuser),
        .cfg_ch_en(cfg_ch_en), .cfg_local_port(cfg_local_port),
        .cfg_remote_ip(cfg_remote_ip), .cfg_remote_port(cfg_remote_port),
        .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .m_tlast(m_tlast), .m_terr(m_terr), .m_tch(m_tch),
        .m_src_ip(m_src_ip), .m_src_port(m_src_port),
        .stat_clr(stat_clr), .stat_rx_pkts(stat_rx_pkts),
        .stat_drop_pkts(stat_drop_pkts), .stat_err_pkts(stat_err_pkts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [31:0] IP_A = 32'hC0A8_0164;   // 192.168.1.100
    localparam logic [31:0] IP_B = 32'h0A00_0001;   // 10.0.0.1

    logic        c_en    [NUM_CH];
    logic [15:0] c_lport [NUM_CH];
    logic [31:0] c_rip   [NUM_CH];
    logic [15:0] c_rport [NUM_CH];

    always_comb begin
        cfg_ch_en       = '0;
        cfg_local_port  = '0;
        cfg_remote_ip   = '0;
        cfg_remote_port = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cfg_ch_en[i]              = c_en[i];
            cfg_local_port[16*i +: 16] = c_lport[i];
            cfg_remote_ip[32*i +: 32]  = c_rip[i];
            cfg_remote_port[16*i +: 16] = c_rport[i];
        end
    end

    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic        err;
        logic [1:0]  ch;
        logic [31:0] ip;
        logic [15:0] port;
    } beat_t;

    beat_t       exp_q[$];
    logic [7:0]  pay [0:63];
    logic [63:0] obs_data [0:15];
    logic [7:0]  obs_keep [0:15];
    logic        obs_last [0:15];
    logic        obs_err  [0:15];
    logic [1:0]  obs_ch   [0:15];
    int          obs_n;

    int n_chk;
    int n_fail;
    int exp_rx, exp_drop, exp_err;
    int cyc, low_until;
    bit rnd_rdy;
    bit pl_fire, hdr_fire, saw_stall, stall_q;
    logic [63:0] prev_data;
    logic [7:0]  prev_keep;
    logic        prev_last;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    function automatic int match_ch(input logic [15:0] dport, input logic [31:0] ip,
                                    input logic [15:0] sport);
        for (int i = 0; i < NUM_CH; i++) begin
            if (c_en[i] && dport == c_lport[i] &&
                (c_rip[i] == 32'd0 || c_rip[i] == ip) &&
                (c_rport[i] == 16'd0 || c_rport[i] == sport))
                return i;
        end
        return -1;
    endfunction

    // Split the datagram into BYTES-wide beats, first byte in lane 0.
    task automatic enqueue(input int n, input int ch, input logic [31:0] ip,
                           input logic [15:0] port, input bit err);
        beat_t b;
        for (int s = 0; s < n; s += BYTES) begin
            b.data = '0;
            b.keep = '0;
            for (int k = 0; k < BYTES; k++) begin
                if (s + k < n) begin
                    b.data[8*k +: 8] = pay[s + k];
                    b.keep[k] = 1'b1;
                end
            end
            b.last = (s + BYTES >= n);
            b.err  = b.last && err;
            b.ch   = 2'(ch);
            b.ip   = ip;
            b.port = port;
            exp_q.push_back(b);
        end
    endtask

    // Sampled at the falling edge: scores beats and records pending handshakes.
    task automatic monitor();
        beat_t e;
        if (rst_n) begin
            if (stall_q) begin
                chk("stall_valid", 64'(m_tvalid), 64'd1);
                chk("stall_data", m_tdata, prev_data);
                chk("stall_keep", 64'(m_tkeep), 64'(prev_keep));
                chk("stall_last", 64'(m_tlast), 64'(prev_last));
            end
            if (m_tvalid && !m_tlast) chk("terr_nonlast", 64'(m_terr), 64'd0);
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got data 0x%0h keep 0x%0h, expected no beat",
                             m_tdata, m_tkeep);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_data", m_tdata, e.data);
                    chk("beat_keep", 64'(m_tkeep), 64'(e.keep));
                    chk("beat_last", 64'(m_tlast), 64'(e.last));
                    chk("beat_err", 64'(m_terr), 64'(e.err));
                    chk("beat_ch", 64'(m_tch), 64'(e.ch));
                    chk("beat_ip", 64'(m_src_ip), 64'(e.ip));
                    chk("beat_port", 64'(m_src_port), 64'(e.port));
                end
                if (obs_n < 16) begin
                    obs_data[obs_n] = m_tdata;
                    obs_keep[obs_n] = m_tkeep;
                    obs_last[obs_n] = m_tlast;
                    obs_err[obs_n]  = m_terr;
                    obs_ch[obs_n]   = m_tch;
                    obs_n++;
                end
            end
            stall_q   = m_tvalid && !m_tready;
            prev_data = m_tdata;
            prev_keep = m_tkeep;
            prev_last = m_tlast;
        end else begin
            stall_q = 1'b0;
        end
        pl_fire  = s_pl_tvalid && s_pl_tready;
        hdr_fire = s_hdr_valid && s_hdr_ready;
        if (s_pl_tvalid && !s_pl_tready) saw_stall = 1'b1;
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        cyc++;
        m_tready = (cyc >= low_until) && (rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1);
    endtask

    task automatic send_packet(input logic [15:0] dport, input logic [31:0] ip,
                               input logic [15:0] sport, input logic [15:0] ulen,
                               input int n, input bit tuser, input int gap_max,
                               input int bp_at, input int abort_at, output int waits);
        int ch, t, exp_len;
        bit err;
        waits = 0;
        s_hdr_dest_port  = dport;
        s_hdr_src_ip     = ip;
        s_hdr_src_port   = sport;
        s_hdr_udp_length = ulen;
        s_hdr_valid      = 1'b1;
        t = 0;
        do begin step(); t++; end while (!hdr_fire && t < 300);
        s_hdr_valid = 1'b0;
        if (!hdr_fire) begin
            chk("hdr_timeout", 64'd0, 64'd1);
            return;
        end
        ch      = match_ch(dport, ip, sport);
        exp_len = (ulen < 16'd8) ? 0 : int'(ulen) - 8;
        err     = tuser || (n != exp_len);
        if (stat_clr) begin
            exp_rx = 0; exp_drop = 0; exp_err = 0;
        end else if (ch >= 0) exp_rx++;
        else exp_drop++;
        if (ch >= 0) begin
            enqueue(n, ch, ip, sport, err);
            if (err) exp_err++;
        end
        for (int i = 0; i < n; i++) begin
            if (gap_max > 0) begin
                s_pl_tvalid = 1'b0;
                repeat ($urandom_range(0, gap_max)) step();
            end
            if (i == abort_at) begin
                s_pl_tvalid = 1'b0;
                return;
            end
            s_pl_tvalid = 1'b1;
            s_pl_tdata  = pay[i];
            s_pl_tlast  = (i == n - 1);
            s_pl_tuser  = tuser && (i == n - 1);
            if (i == bp_at) low_until = cyc + 10;
            t = 0;
            do begin
                step();
                if (!pl_fire) waits++;
                t++;
            end while (!pl_fire && t < 300);
            if (!pl_fire) begin
                chk("byte_timeout", 64'd0, 64'd1);
                s_pl_tvalid = 1'b0;
                return;
            end
        end
        s_pl_tvalid = 1'b0;
        s_pl_tlast  = 1'b0;
        s_pl_tuser  = 1'b0;
        if (ch < 0) chk("drop_tready_held", 64'(waits), 64'd0);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || m_tvalid) && t < 1000) begin
            step();
            t++;
        end
        chk("drain_pending_beats", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_stats();
        chk("stat_rx", 64'(stat_rx_pkts), 64'(exp_rx));
        chk("stat_drop", 64'(stat_drop_pkts), 64'(exp_drop));
        chk("stat_err", 64'(stat_err_pkts), 64'(exp_err));
    endtask

    task automatic load_seq(input int n);
        for (int i = 0; i < n; i++) pay[i] = 8'(i);
    endtask

    task automatic load_rand(input int n);
        for (int i = 0; i < n; i++) pay[i] = 8'($urandom_range(0, 255));
    endtask

    // Reference datagram of the first scenario, pinned to literal words.
    task automatic run_ref_packet(input string tag);
        int w;
        load_seq(11);
        obs_n = 0;
        send_packet(16'd5000, IP_A, 16'd6000, 16'd19, 11, 1'b0, 0, -1, -1, w);
        chk({tag, "_first_byte_no_wait"}, 64'(w), 64'd0);
        drain();
        chk({tag, "_beats"}, 64'(obs_n), 64'd2);
        chk({tag, "_b1_data"}, obs_data[0], 64'h0706050403020100);
        chk({tag, "_b1_keep"}, 64'(obs_keep[0]), 64'hFF);
        chk({tag, "_b1_last"}, 64'(obs_last[0]), 64'd0);
        chk({tag, "_b2_data"}, obs_data[1], 64'h0000_0000_000A_0908);
        chk({tag, "_b2_keep"}, 64'(obs_keep[1]), 64'h07);
        chk({tag, "_b2_last"}, 64'(obs_last[1]), 64'd1);
        chk({tag, "_b2_err"}, 64'(obs_err[1]), 64'd0);
        chk({tag, "_b2_ch"}, 64'(obs_ch[1]), 64'd0);
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1);
    end

    initial begin
        int w;
        int kind, n, ch_pick;
        logic [15:0] dport, sport, ulen;
        logic [31:0] ip;
        bit tuser;

        n_chk = 0; n_fail = 0; exp_rx = 0; exp_drop = 0; exp_err = 0;
        cyc = 0; low_until = 0; rnd_rdy = 0; obs_n = 0;
        pl_fire = 0; hdr_fire = 0; saw_stall = 0; stall_q = 0;
        prev_data = '0; prev_keep = '0; prev_last = 1'b0;
        rst_n = 1'b0; m_tready = 1'b1; stat_clr = 1'b0;
        s_hdr_valid = 1'b0; s_hdr_src_ip = '0; s_hdr_src_port = '0;
        s_hdr_dest_port = '0; s_hdr_udp_length = '0;
        s_pl_tdata = '0; s_pl_tvalid = 1'b0; s_pl_tlast = 1'b0; s_pl_tuser = 1'b0;
        c_en[0] = 1; c_lport[0] = 16'd5000; c_rip[0] = IP_A;  c_rport[0] = 16'd6000;
        c_en[1] = 1; c_lport[1] = 16'd7000; c_rip[1] = IP_B;  c_rport[1] = 16'd0;
        c_en[2] = 1; c_lport[2] = 16'd7000; c_rip[2] = 32'd0; c_rport[2] = 16'd0;
        c_en[3] = 1; c_lport[3] = 16'd8000; c_rip[3] = 32'd0; c_rport[3] = 16'd1234;

        #22;
        chk("reset_hdr_ready", 64'(s_hdr_ready), 64'd0);
        chk("reset_pl_tready", 64'(s_pl_tready), 64'd0);
        chk("reset_m_tvalid", 64'(m_tvalid), 64'd0);
        chk("reset_m_tdata", m_tdata, 64'd0);
        chk("reset_stat_rx", 64'(stat_rx_pkts), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        chk("hdr_ready_after_reset", 64'(s_hdr_ready), 64'd1);

        // Reference datagram.
        run_ref_packet("t1");
        chk("t1_stat_rx", 64'(stat_rx_pkts), 64'd1);

        // Unmatched destination port is dropped, then a matching one passes.
        load_rand(20);
        obs_n = 0;
        send_packet(16'd5001, IP_A, 16'd6000, 16'd28, 20, 1'b0, 0, -1, -1, w);
        drain();
        chk("t2_no_beats", 64'(obs_n), 64'd0);
        chk("t2_stat_drop", 64'(stat_drop_pkts), 64'd1);
        run_ref_packet("t2b");
        chk("t2_stat_rx", 64'(stat_rx_pkts), 64'd2);

        // Priority between an exact-IP channel and a wildcard channel.
        load_rand(5);
        obs_n = 0;
        send_packet(16'd7000, IP_B, 16'd9, 16'd13, 5, 1'b0, 0, -1, -1, w);
        drain();
        chk("t3_exact_wins_ch", 64'(obs_ch[0]), 64'd1);
        c_en[1] = 0;
        obs_n = 0;
        send_packet(16'd7000, IP_B, 16'd9, 16'd13, 5, 1'b0, 0, -1, -1, w);
        drain();
        chk("t3_wildcard_ch", 64'(obs_ch[0]), 64'd2);
        c_en[1] = 1;

        // Output stall after beat 1 forces a held word.
        load_rand(24);
        saw_stall = 0;
        send_packet(16'd5000, IP_A, 16'd6000, 16'd32, 24, 1'b0, 0, 7, -1, w);
        drain();
        chk("t4_tready_dropped", 64'(saw_stall), 64'd1);

        // Full rate: 24 bytes, no waits.
        load_rand(24);
        send_packet(16'd5000, IP_A, 16'd6000, 16'd32, 24, 1'b0, 0, -1, -1, w);
        chk("t4_throughput_waits", 64'(w), 64'd0);
        drain();

        // Short datagram against its length field, then a core error flag.
        load_rand(10);
        obs_n = 0;
        send_packet(16'd5000, IP_A, 16'd6000, 16'd24, 10, 1'b0, 0, -1, -1, w);
        drain();
        chk("t5_len_err", 64'(obs_err[1]), 64'd1);
        chk("t5_len_err_keep", 64'(obs_keep[1]), 64'h03);
        chk("t5_stat_err", 64'(stat_err_pkts), 64'd1);
        load_rand(6);
        obs_n = 0;
        send_packet(16'd5000, IP_A, 16'd6000, 16'd14, 6, 1'b1, 0, -1, -1, w);
        drain();
        chk("t5_tuser_err", 64'(obs_err[0]), 64'd1);
        chk("t5_stat_err2", 64'(stat_err_pkts), 64'd2);
        check_stats();

        // Reset in the middle of a passing datagram.
        load_seq(11);
        send_packet(16'd5000, IP_A, 16'd6000, 16'd19, 11, 1'b0, 0, -1, 5, w);
        rst_n = 1'b0;
        #1;
        chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
        chk("rst_m_tdata", m_tdata, 64'd0);
        chk("rst_m_tkeep", 64'(m_tkeep), 64'd0);
        chk("rst_m_tlast", 64'(m_tlast), 64'd0);
        chk("rst_m_src_ip", 64'(m_src_ip), 64'd0);
        chk("rst_hdr_ready", 64'(s_hdr_ready), 64'd0);
        chk("rst_pl_tready", 64'(s_pl_tready), 64'd0);
        chk("rst_stat_rx", 64'(stat_rx_pkts), 64'd0);
        chk("rst_stat_err", 64'(stat_err_pkts), 64'd0);
        exp_q.delete();
        exp_rx = 0; exp_drop = 0; exp_err = 0;
        s_pl_tvalid = 1'b1;
        s_pl_tdata  = 8'h55;
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("idle_byte_not_taken", 64'(pl_fire), 64'd0);
        end
        s_pl_tvalid = 1'b0;
        run_ref_packet("t6");
        check_stats();

        // Clear coinciding with the rx increment.
        load_seq(11);
        stat_clr = 1'b1;
        send_packet(16'd5000, IP_A, 16'd6000, 16'd19, 11, 1'b0, 0, -1, -1, w);
        stat_clr = 1'b0;
        drain();
        chk("clr_stat_rx", 64'(stat_rx_pkts), 64'd0);
        check_stats();

        // Randomized traffic with random sink backpressure.
        rnd_rdy = 1;
        for (int p = 0; p < 60; p++) begin
            kind = $urandom_range(0, 3);
            n    = $urandom_range(1, 40);
            ip   = 32'($urandom);
            sport = 16'($urandom_range(1, 65535));
            case (kind)
                0: begin dport = 16'd5000; ip = IP_A; sport = ($urandom_range(0, 3) == 0) ? 16'd6001 : 16'd6000; end
                1: begin dport = 16'd7000; if ($urandom_range(0, 1) == 1) ip = IP_B; end
                2: begin dport = 16'd8000; if ($urandom_range(0, 1) == 1) sport = 16'd1234; end
                default: begin
                    ch_pick = $urandom_range(0, 4);
                    dport = (ch_pick == 4) ? 16'($urandom) : c_lport[ch_pick];
                end
            endcase
            ulen  = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(0, 60)) : 16'(n + 8);
            tuser = ($urandom_range(0, 7) == 0);
            load_rand(n);
            send_packet(dport, ip, sport, ulen, n, tuser, 2, -1, -1, w);
        end
        rnd_rdy = 0;
        step();
        drain();
        check_stats();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
